// File: rtl/bus_burst_master_pkg.sv
// rtl/bus_burst_master_pkg.sv - shared state encodings and bus defaults for the burst master
//
// Purpose: common definitions reused by the burst master, its timeout counter,
//          and the slave/arbiter models that speak the same bus.
// Contents: state_t (IDLE/REQ/XFER), default bus widths, counter width helper.
package bus_burst_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    localparam int DEF_ADDR_WIDTH  = 16;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_MAX_BURST   = 8;
    localparam int DEF_TIMEOUT_CYC = 255;

    // Bits needed to hold values 0..max_val.
    function automatic int ctr_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// rtl/bus_timeout_ctr.sv - cycle counter that flags expiry after TIMEOUT_CYC enabled cycles
//
// Purpose: shared watchdog for the grant wait and the per-beat ack wait.
// Ports:
//   clk       in  clock
//   rstn      in  synchronous active-low reset
//   i_clear   in  restart count at 0 (wins over i_enable)
//   i_enable  in  count this cycle
//   o_expire  out combinational: this enabled cycle is the TIMEOUT_CYC-th one
module bus_timeout_ctr
    import bus_burst_master_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CW = ctr_width(TIMEOUT_CYC);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CW'(1);
        end
    end

    // Flag on the last allowed cycle so the owner's registered err lands
    // exactly TIMEOUT_CYC cycles after the wait began.
    assign o_expire = i_enable && (r_count == LAST);

endmodule

// File: rtl/bus_burst_master.sv
// rtl/bus_burst_master.sv - burst bus master with grant/ack timeouts and grant-loss recovery
//
// Purpose: accepts read/write burst commands, arbitrates via breq/bgrant, and
//          moves one beat at a time over addr/wdata/wen/ren with incrementing address.
// Ports:
//   clk, rstn                    clock, synchronous active-low reset
//   cmd_valid/ready/write/addr/len  command channel (len = beats-1)
//   wd_valid/ready/data          write beat data channel (wd_ready is combinational)
//   rsp_valid/rsp_data           read beat data, one-cycle pulse, no backpressure
//   done, err                    one-cycle completion / timeout-abort pulses
//   breq, bgrant                 arbiter request / grant
//   addr, wdata, wen, ren        slave beat outputs
//   sready, rdata                slave beat completion and read data
module bus_burst_master
    import bus_burst_master_pkg::*;
#(
    parameter  int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter  int MAX_BURST   = DEF_MAX_BURST,
    parameter  int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    localparam int LEN_W       = $clog2(MAX_BURST)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic                  wd_valid,
    output logic                  wd_ready,
    input  logic [DATA_WIDTH-1:0] wd_data,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  done,
    output logic                  err,
    output logic                  breq,
    input  logic                  bgrant,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wen,
    output logic                  ren,
    input  logic                  sready,
    input  logic [DATA_WIDTH-1:0] rdata
);

    state_t                r_state;
    state_t                w_next_state;

    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_W:0]        r_beats_left;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_wbuf;      // write beat captured, not yet acknowledged
    logic                  r_wen;
    logic                  r_ren;
    logic                  r_breq;
    logic                  r_cmd_ready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_done;
    logic                  r_err;

    logic                  w_cmd_fire;
    logic                  w_wd_fire;
    logic                  w_strobe;
    logic                  w_beat_done;
    logic                  w_last_beat;
    logic                  w_tmr_enable;
    logic                  w_tmr_clear;
    logic                  w_tmr_expire;
    logic                  w_done_set;
    logic                  w_err_set;
    logic                  w_wbuf_nxt;
    logic                  w_wen_nxt;
    logic                  w_ren_nxt;
    logic                  w_breq_nxt;
    logic                  w_cmd_ready_nxt;

    // r_cmd_ready is only ever high in IDLE, so it doubles as the accept qualifier.
    assign w_cmd_fire  = cmd_valid & r_cmd_ready;
    assign wd_ready    = (r_state == ST_XFER) & r_write & ~r_wbuf & bgrant;
    assign w_wd_fire   = wd_valid & wd_ready;
    assign w_strobe    = r_wen | r_ren;
    // sready only means something while a strobe is out.
    assign w_beat_done = (r_state == ST_XFER) & w_strobe & sready;
    assign w_last_beat = w_beat_done & (r_beats_left == (LEN_W + 1)'(1));

    // One counter serves both waits: REQ and XFER never overlap, and any
    // state change or completed beat restarts it.
    assign w_tmr_enable = (r_state == ST_REQ) | ((r_state == ST_XFER) & w_strobe);
    assign w_tmr_clear  = (w_next_state != r_state) | w_beat_done;

    bus_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk      (clk),
        .rstn     (rstn),
        .i_clear  (w_tmr_clear),
        .i_enable (w_tmr_enable),
        .o_expire (w_tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_done_set   = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_fire) begin
                    w_next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                // A grant arriving on the expiry cycle still wins.
                if (bgrant) begin
                    w_next_state = ST_XFER;
                end else if (w_tmr_expire) begin
                    w_next_state = ST_IDLE;
                    w_err_set    = 1'b1;
                end
            end
            ST_XFER: begin
                // A beat acknowledged as the grant falls still counts; only
                // the remainder goes back through REQ.
                if (w_last_beat) begin
                    w_next_state = ST_IDLE;
                    w_done_set   = 1'b1;
                end else if (w_tmr_expire && !w_beat_done) begin
                    w_next_state = ST_IDLE;
                    w_err_set    = 1'b1;
                end else if (!bgrant) begin
                    w_next_state = ST_REQ;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        // Captured write data survives a grant loss so the beat can be re-issued.
        if (w_next_state == ST_IDLE) begin
            w_wbuf_nxt = 1'b0;
        end else begin
            w_wbuf_nxt = (r_wbuf & ~w_beat_done) | w_wd_fire;
        end

        w_wen_nxt       = (w_next_state == ST_XFER) & r_write & w_wbuf_nxt;
        w_ren_nxt       = (w_next_state == ST_XFER) & ~r_write;
        w_breq_nxt      = (w_next_state != ST_IDLE);
        w_cmd_ready_nxt = (w_next_state == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_beats_left <= '0;
            r_wdata      <= '0;
            r_wbuf       <= 1'b0;
            r_wen        <= 1'b0;
            r_ren        <= 1'b0;
            r_breq       <= 1'b0;
            r_cmd_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_wbuf      <= w_wbuf_nxt;
            r_wen       <= w_wen_nxt;
            r_ren       <= w_ren_nxt;
            r_breq      <= w_breq_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_done      <= w_done_set;
            r_err       <= w_err_set;
            r_rsp_valid <= w_beat_done & ~r_write;

            if (w_beat_done && !r_write) begin
                r_rsp_data <= rdata;
            end

            if (w_wd_fire) begin
                r_wdata <= wd_data;
            end

            if (w_cmd_fire) begin
                r_write      <= cmd_write;
                r_addr       <= cmd_addr;
                r_beats_left <= {1'b0, cmd_len} + (LEN_W + 1)'(1);
            end else begin
                if (w_beat_done) begin
                    r_addr <= r_addr + ADDR_WIDTH'(1);
                end
                // Leaving the burst (done or abort) drops any remaining beats.
                if (w_next_state == ST_IDLE) begin
                    r_beats_left <= '0;
                end else if (w_beat_done) begin
                    r_beats_left <= r_beats_left - (LEN_W + 1)'(1);
                end
            end
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign done      = r_done;
    assign err       = r_err;
    assign breq      = r_breq;
    assign addr      = r_addr;
    assign wdata     = r_wdata;
    assign wen       = r_wen;
    assign ren       = r_ren;

endmodule

// File: tb/tb_bus_burst_master.sv
// tb/tb_bus_burst_master.sv - scoreboard bench for bus_burst_master
module tb_bus_burst_master;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int MB = 8;
    localparam int TO = 8;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          wd_valid;
    logic          wd_ready;
    logic [DW-1:0] wd_data;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          done;
    logic          err;
    logic          breq;
    logic          bgrant;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          wen;
    logic          ren;
    logic          sready = 1'b0;
    logic [DW-1:0] rdata  = '0;

    always #5 clk = ~clk;

    bus_burst_master #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .MAX_BURST   (MB),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wd_valid  (wd_valid),
        .wd_ready  (wd_ready),
        .wd_data   (wd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .done      (done),
        .err       (err),
        .breq      (breq),
        .bgrant    (bgrant),
        .addr      (addr),
        .wdata     (wdata),
        .wen       (wen),
        .ren       (ren),
        .sready    (sready),
        .rdata     (rdata)
    );

    typedef enum int {EV_RBEAT, EV_WBEAT, EV_RSP, EV_DONE, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [63:0] val;
    } ev_t;

    ev_t sb_q[$];
    int  n_checks  = 0;
    int  n_errors  = 0;
    int  n_beats   = 0;
    int  n_done    = 0;
    int  n_err     = 0;
    int  slv_delay = 1;
    int  slv_cnt   = 0;
    bit  slv_stuck = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [15:0] a);
        return {a ^ 16'hC3A5, a};
    endfunction

    task automatic sb_push(input ev_kind_t kind, input logic [63:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_match(input ev_kind_t kind, input logic [63:0] val);
        ev_t e;
        if (sb_q.size() == 0) begin
            check($sformatf("sb_underflow_kind%0d", kind), 64'(sb_q.size()), 64'd1);
        end else begin
            e = sb_q.pop_front();
            check($sformatf("sb_kind_%0d", e.kind), 64'(kind), 64'(e.kind));
            check($sformatf("sb_val_kind%0d", e.kind), val, e.val);
        end
    endtask

    // Slave model plus output monitor: decides sready for the coming edge
    // and scores every DUT-visible event against the expected queue.
    always @(negedge clk) begin
        if (rstn) begin
            if (rsp_valid) sb_match(EV_RSP, 64'(rsp_data));
            if (done) begin
                n_done++;
                sb_match(EV_DONE, 64'd0);
            end
            if (err) begin
                n_err++;
                sb_match(EV_ERR, 64'd0);
            end
        end
        if (rstn && (ren || wen) && !slv_stuck) begin
            if (slv_cnt >= slv_delay) begin
                sready  = 1'b1;
                rdata   = rd_model(addr);
                slv_cnt = 0;
                n_beats++;
                if (wen) sb_match(EV_WBEAT, 64'({addr, wdata}));
                else     sb_match(EV_RBEAT, 64'({addr, 32'h0}));
            end else begin
                sready  = 1'b0;
                rdata   = 32'hDEAD_BEEF;
                slv_cnt++;
            end
        end else begin
            sready  = 1'b0;
            slv_cnt = 0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input bit w, input logic [15:0] a, input int len);
        int g = 0;
        while (!cmd_ready && g < 50) begin
            tick();
            g++;
        end
        check("cmd_ready_before_issue", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = LW'(len);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic push_read(input logic [15:0] a, input int beats);
        logic [15:0] ai;
        for (int i = 0; i < beats; i++) begin
            ai = a + 16'(i);
            sb_push(EV_RBEAT, 64'({ai, 32'h0}));
            sb_push(EV_RSP, 64'(rd_model(ai)));
        end
        sb_push(EV_DONE, 64'd0);
    endtask

    task automatic send_wd(input logic [31:0] d);
        int g = 0;
        wd_valid = 1'b1;
        wd_data  = d;
        while (!wd_ready && g < 50) begin
            tick();
            g++;
        end
        check("wd_accept", 64'(wd_ready), 64'd1);
        tick();
        wd_valid = 1'b0;
    endtask

    task automatic wait_end();
        int base = n_done + n_err;
        int g    = 0;
        while ((n_done + n_err) == base && g < 200) begin
            tick();
            g++;
        end
        check("wait_end", 64'(n_done + n_err), 64'(base + 1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int cyc;
        int g;
        rstn      = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wd_valid  = 1'b0;
        wd_data   = '0;
        bgrant    = 1'b0;
        tick();
        tick();
        check("rst_ctrl", 64'({cmd_ready, rsp_valid, done, err, breq, wen, ren, wd_ready}), 64'd0);
        check("rst_addr", 64'(addr), 64'd0);
        check("rst_wdata", 64'(wdata), 64'd0);
        rstn = 1'b1;
        tick();
        check("rst_release_cmd_ready", 64'(cmd_ready), 64'd1);

        // 1: read burst, late grant
        b0 = n_beats;
        push_read(16'h0010, 4);
        issue(1'b0, 16'h0010, 3);
        check("t1_breq_up", 64'(breq), 64'd1);
        tick();
        tick();
        bgrant = 1'b1;
        wait_end();
        check("t1_beats", 64'(n_beats - b0), 64'd4);
        check("t1_breq_low", 64'(breq), 64'd0);
        check("t1_cmd_ready", 64'(cmd_ready), 64'd1);
        tick();
        check("t1_done_pulse", 64'(done), 64'd0);

        // 2: write burst at top of address space with a gap between beats
        sb_push(EV_WBEAT, 64'({16'hFFFF, 32'hA1B2C3D4}));
        sb_push(EV_WBEAT, 64'({16'h0000, 32'h5566_7788}));
        sb_push(EV_DONE, 64'd0);
        issue(1'b1, 16'hFFFF, 1);
        send_wd(32'hA1B2C3D4);
        tick();
        tick();
        tick();
        check("t2_wen_gap", 64'(wen), 64'd0);
        check("t2_breq_gap", 64'(breq), 64'd1);
        send_wd(32'h5566_7788);
        wait_end();
        check("t2_addr_wrap", 64'(addr), 64'd1);

        // 3: grant never comes
        bgrant = 1'b0;
        sb_push(EV_ERR, 64'd0);
        b0 = n_err;
        issue(1'b0, 16'h0100, 2);
        check("t3_breq_up", 64'(breq), 64'd1);
        cyc = 0;
        while (n_err == b0 && cyc < 50) begin
            tick();
            cyc++;
        end
        check("t3_err_latency", 64'(cyc), 64'(TO));
        check("t3_breq_low", 64'(breq), 64'd0);
        check("t3_cmd_ready", 64'(cmd_ready), 64'd1);

        // 4: grant withdrawn for 5 cycles after the second beat
        bgrant = 1'b1;
        b0 = n_beats;
        push_read(16'h0200, 4);
        issue(1'b0, 16'h0200, 3);
        g = 0;
        while (n_beats < b0 + 2 && g < 100) begin
            tick();
            g++;
        end
        bgrant = 1'b0;
        tick();
        check("t4_ren_low", 64'(ren), 64'd0);
        check("t4_breq_held", 64'(breq), 64'd1);
        check("t4_addr_hold", 64'(addr), 64'h0202);
        repeat (4) tick();
        check("t4_no_beats_while_lost", 64'(n_beats - b0), 64'd2);
        bgrant = 1'b1;
        wait_end();
        check("t4_beats", 64'(n_beats - b0), 64'd4);

        // 5: slave never acknowledges a write beat
        slv_stuck = 1'b1;
        sb_push(EV_ERR, 64'd0);
        b0 = n_err;
        issue(1'b1, 16'h0300, 2);
        send_wd(32'hCAFE_F00D);
        check("t5_wen_up", 64'(wen), 64'd1);
        cyc = 0;
        while (n_err == b0 && cyc < 50) begin
            tick();
            cyc++;
        end
        check("t5_ack_latency", 64'(cyc), 64'(TO));
        check("t5_strobes_low", 64'({wen, ren, breq}), 64'd0);
        check("t5_wd_ready_low", 64'(wd_ready), 64'd0);
        check("t5_cmd_ready", 64'(cmd_ready), 64'd1);
        slv_stuck = 1'b0;

        // 6: reset in the middle of a burst, then a clean burst
        slv_delay = 6;
        issue(1'b0, 16'h0400, 3);
        g = 0;
        while (!ren && g < 20) begin
            tick();
            g++;
        end
        check("t6_ren_up", 64'(ren), 64'd1);
        tick();
        tick();
        rstn = 1'b0;
        tick();
        check("t6_rst_ctrl", 64'({cmd_ready, rsp_valid, done, err, breq, wen, ren}), 64'd0);
        check("t6_rst_addr", 64'(addr), 64'd0);
        rstn      = 1'b1;
        slv_delay = 1;
        tick();
        push_read(16'h0040, 2);
        issue(1'b0, 16'h0040, 1);
        wait_end();
        tick();
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
